// File: rtl/lathe_seq_pkg.sv
// Shared types for the lathe cycle sequencer: state encoding, fault codes,
// operator mode decode and per-state output drive table.
package lathe_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRECOOL = 3'd1,
    ST_SPIN_UP = 3'd2,
    ST_FEED    = 3'd3,
    ST_DWELL   = 3'd4,
    ST_RETRACT = 3'd5,
    ST_MAN_RUN = 3'd6,
    ST_FAULT   = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    MODE_INVALID = 2'd0,
    MODE_AUTO    = 2'd1,
    MODE_MAN     = 2'd2
  } mode_e;

  localparam logic [1:0] FC_NONE  = 2'd0;
  localparam logic [1:0] FC_ESTOP = 2'd1;
  localparam logic [1:0] FC_OVLD  = 2'd2;
  localparam logic [1:0] FC_WDOG  = 2'd3;

  typedef struct packed {
    logic coolant;
    logic spindle;
    logic fwd;
    logic rev;
  } drive_t;

  // Both selectors high or both low is treated as an invalid selector position.
  function automatic mode_e decode_mode(input logic auto_sel, input logic man_sel);
    if (auto_sel && !man_sel)      return MODE_AUTO;
    else if (man_sel && !auto_sel) return MODE_MAN;
    else                           return MODE_INVALID;
  endfunction

  function automatic drive_t drive_for(input state_e st);
    drive_t d;
    d = '0;
    case (st)
      ST_PRECOOL:                     d.coolant = 1'b1;
      ST_SPIN_UP, ST_DWELL, ST_MAN_RUN: begin
        d.coolant = 1'b1;
        d.spindle = 1'b1;
      end
      ST_FEED: begin
        d.coolant = 1'b1;
        d.spindle = 1'b1;
        d.fwd     = 1'b1;
      end
      ST_RETRACT: begin
        d.coolant = 1'b1;
        d.spindle = 1'b1;
        d.rev     = 1'b1;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lathe_cycle_sequencer_ton_timer.sv
// On-delay timer: counts cycles since the last clear, saturating; done means
// the coming clock edge is the preset-th edge since the clear.
module ton_timer #(
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [TW-1:0] preset,
  output logic          done
);

  logic [TW-1:0] cnt_q;
  logic [TW:0]   edges_at_next;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (cnt_q != '1) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // One extra bit keeps the +1 from wrapping at saturation.
  assign edges_at_next = {1'b0, cnt_q} + {{TW{1'b0}}, 1'b1};
  assign done          = edges_at_next >= {1'b0, preset};

endmodule

// File: rtl/lathe_cycle_sequencer.sv
// Moore sequencer for one automatic turning cycle plus manual spindle run,
// with latched faults and a single shared dwell/watchdog timer.
module lathe_cycle_sequencer
  import lathe_seq_pkg::*;
#(
  parameter int TW         = 16,
  parameter int T_COOL     = 16,
  parameter int T_SPIN     = 64,
  parameter int T_DWELL    = 32,
  parameter int T_MOVE_MAX = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       auto_mode,
  input  logic       man_mode,
  input  logic       estop,
  input  logic       overload,
  input  logic       end_limit,
  input  logic       home_limit,
  input  logic       fault_ack,
  output logic       coolant_on,
  output logic       spindle_on,
  output logic       feed_fwd,
  output logic       feed_rev,
  output logic       cycle_done,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [2:0] state_o
);

  localparam logic [TW-1:0] P_COOL = TW'(T_COOL);
  localparam logic [TW-1:0] P_SPIN = TW'(T_SPIN);
  localparam logic [TW-1:0] P_DWELL = TW'(T_DWELL);
  localparam logic [TW-1:0] P_MOVE = TW'(T_MOVE_MAX);

  state_e        state_q, state_d;
  logic [1:0]    fault_code_q, fault_code_d;
  logic          start_q;
  logic          from_dwell_q, from_dwell_d;
  drive_t        drive_q, drive_d;
  logic          cycle_done_q;
  logic          fault_q;
  logic [TW-1:0] preset;
  logic          tmr_done;
  logic          start_rise;
  logic          leave_auto;
  mode_e         mode;

  assign mode       = decode_mode(auto_mode, man_mode);
  assign start_rise = start & ~start_q;
  assign leave_auto = stop | (mode != MODE_AUTO);

  always_comb begin
    case (state_q)
      ST_PRECOOL:          preset = P_COOL;
      ST_SPIN_UP:          preset = P_SPIN;
      ST_DWELL:            preset = P_DWELL;
      ST_FEED, ST_RETRACT: preset = P_MOVE;
      default:             preset = '1;
    endcase
  end

  ton_timer #(.TW(TW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_d != state_q),
    .preset (preset),
    .done   (tmr_done)
  );

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    fault_code_d = fault_code_q;
    if (state_q != ST_FAULT && estop) begin
      state_d      = ST_FAULT;
      fault_code_d = FC_ESTOP;
    end else if (state_q != ST_FAULT && overload) begin
      state_d      = ST_FAULT;
      fault_code_d = FC_OVLD;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_rise && !stop) begin
            if (mode == MODE_AUTO && home_limit) state_d = ST_PRECOOL;
            else if (mode == MODE_MAN)           state_d = ST_MAN_RUN;
          end
        end
        ST_PRECOOL: begin
          if (leave_auto)    state_d = ST_RETRACT;
          else if (tmr_done) state_d = ST_SPIN_UP;
        end
        ST_SPIN_UP: begin
          if (leave_auto)    state_d = ST_RETRACT;
          else if (tmr_done) state_d = ST_FEED;
        end
        ST_FEED: begin
          if (tmr_done) begin
            state_d      = ST_FAULT;
            fault_code_d = FC_WDOG;
          end else if (leave_auto) begin
            state_d = ST_RETRACT;
          end else if (end_limit) begin
            state_d = ST_DWELL;
          end
        end
        ST_DWELL: begin
          if (leave_auto || tmr_done) state_d = ST_RETRACT;
        end
        ST_RETRACT: begin
          if (tmr_done) begin
            state_d      = ST_FAULT;
            fault_code_d = FC_WDOG;
          end else if (home_limit) begin
            state_d = ST_IDLE;
          end
        end
        ST_MAN_RUN: begin
          if (stop || mode != MODE_MAN) state_d = ST_IDLE;
        end
        ST_FAULT: begin
          if (fault_ack && !estop && !overload) begin
            state_d      = ST_IDLE;
            fault_code_d = FC_NONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Only a retract that began at the end of a dwell counts as a completed cycle.
  always_comb begin
    from_dwell_d = from_dwell_q;
    if (state_d == ST_IDLE)                                from_dwell_d = 1'b0;
    else if (state_q == ST_DWELL && state_d == ST_RETRACT) from_dwell_d = 1'b1;
  end

  assign drive_d = drive_for(state_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      fault_code_q <= FC_NONE;
      start_q      <= 1'b0;
      from_dwell_q <= 1'b0;
      drive_q      <= '0;
      cycle_done_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fault_code_q <= fault_code_d;
      start_q      <= start;
      from_dwell_q <= from_dwell_d;
      drive_q      <= drive_d;
      cycle_done_q <= (state_q == ST_RETRACT) && (state_d == ST_IDLE) && from_dwell_q;
      fault_q      <= (state_d == ST_FAULT);
    end
  end

  assign coolant_on = drive_q.coolant;
  assign spindle_on = drive_q.spindle;
  assign feed_fwd   = drive_q.fwd;
  assign feed_rev   = drive_q.rev;
  assign cycle_done = cycle_done_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign state_o    = state_q;

endmodule
